preprocess_pingpong_buf: RTL and testbench

//  Parametrised ping-pong coefficient buffer ahead of the INTT. DP1 fills one bank while the other drains.

---
 rtl/preprocess_pkg.sv | 38 +++
 rtl/preprocess_bank_ram.sv | 42 ++++
 rtl/preprocess_pingpong_buf.sv | 215 +++++++++++++++++++++
 tb/tb_preprocess_pingpong_buf.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/preprocess_pkg.sv
// ----------------------------------------------------------------------------
// preprocess_pkg
//   Shared types and helpers for the ping-pong coefficient buffer.
//   - state_e     : stream FSM states (IDLE/STREAM/FLUSH/DONE)
//   - lane_zext   : keep the low 'keep' bits of a lane, zero the rest
//   - bitrev      : reverse the low 'n' bits of an address
//   Helpers work on fixed maximum widths; callers cast in and out so one
//   function serves every parameterisation.
// ----------------------------------------------------------------------------
package preprocess_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int LANE_MAX_W = 64;
  localparam int ADDR_MAX_W = 32;

  function automatic logic [LANE_MAX_W-1:0] lane_zext(input logic [LANE_MAX_W-1:0] v,
                                                      input int keep);
    lane_zext = '0;
    for (int i = 0; i < LANE_MAX_W; i++) begin
      if (i < keep) lane_zext[i] = v[i];
    end
  endfunction

  function automatic logic [ADDR_MAX_W-1:0] bitrev(input logic [ADDR_MAX_W-1:0] v,
                                                   input int n);
    bitrev = '0;
    for (int i = 0; i < ADDR_MAX_W; i++) begin
      if (i < n) bitrev[i] = v[n-1-i];
    end
  endfunction

endpackage

// File: rtl/preprocess_bank_ram.sv
// ----------------------------------------------------------------------------
// preprocess_bank_ram
//   One coefficient bank: 1 write port, 1 read port, read-first.
//   A read and write to the same address in one cycle returns the old word.
//   Ports:
//     clock_i   : rising-edge clock
//     reset_ni  : async active-low reset (clears the read register only)
//     wren_i    : write enable
//     wraddr_i  : write address
//     wrdata_i  : write word
//     rdaddr_i  : read address (registered, 1-cycle latency)
//     rddata_o  : read word
// ----------------------------------------------------------------------------
module preprocess_bank_ram #(
  parameter int WORD_W     = 280,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock_i,
  input  logic                  reset_ni,
  input  logic                  wren_i,
  input  logic [ADDR_WIDTH-1:0] wraddr_i,
  input  logic [WORD_W-1:0]     wrdata_i,
  input  logic [ADDR_WIDTH-1:0] rdaddr_i,
  output logic [WORD_W-1:0]     rddata_o
);

  logic [WORD_W-1:0] mem_q [2**ADDR_WIDTH];
  logic [WORD_W-1:0] rddata_q;

  // Storage has no reset; only the output register is cleared.
  always_ff @(posedge clock_i) begin
    if (wren_i) mem_q[wraddr_i] <= wrdata_i;
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) rddata_q <= '0;
    else           rddata_q <= mem_q[rdaddr_i];
  end

  assign rddata_o = rddata_q;

endmodule

// File: rtl/preprocess_pingpong_buf.sv
// ----------------------------------------------------------------------------
// preprocess_pingpong_buf
//   Ping-pong coefficient buffer ahead of the INTT. DP1 writes/reads the fill
//   bank; the drain bank is either streamed to the INTT (start/done) or read
//   randomly on the mux port. Bank swap is requested by io_i_pre_switch and
//   applied only when the stream FSM is idle and the mux consumer has
//   released the drain bank (io_i_mux_done).
//
//   Optional build macro: PREPROCESS_BITREV_EN
//     defined   : io_o_intt_addr carries the bit-reversed stream address
//     undefined : io_o_intt_addr carries the stream address as read
//
//   Ports:
//     clock / reset       : clock, async active-low reset
//     io_i_intt_start     : pulse, start streaming from io_i_coeff_index
//     io_o_intt_done      : 1-cycle pulse after the last beat
//     io_o_busy           : stream in progress (FSM not idle)
//     io_i_pre_switch     : pulse, request bank swap
//     io_i_mux_done       : pulse, mux consumer released drain bank
//     io_i_dp1_*          : fill bank write and read-back (1-cycle latency)
//     io_i/o_mux_rd*      : drain bank random read (1-cycle latency)
//     io_o_intt_we/addr/concat : stream beats, lane0 at LSBs
//     io_o_fill_bank      : current fill bank index
//     io_o_switch_pend    : swap requested but not yet applied
//     io_o_dbg_state      : stream FSM state
//
//   Stream handshake: io_i_intt_start is accepted only in IDLE (ignored while
//   streaming and in the DONE cycle). An accepted start at cycle t produces
//   io_o_intt_we on every cycle t+2 .. t+DEPTH+1, then io_o_intt_done at
//   t+DEPTH+2. There is no back-pressure: the INTT must take every beat.
// ----------------------------------------------------------------------------
module preprocess_pingpong_buf #(
  parameter int DATA_WIDTH  = 39,
  parameter int COEFF_WIDTH = 35,
  parameter int ADDR_WIDTH  = 12,
  parameter int LANES       = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         io_i_intt_start,
  output logic                         io_o_intt_done,
  output logic                         io_o_busy,
  input  logic                         io_i_pre_switch,
  input  logic                         io_i_mux_done,
  input  logic [ADDR_WIDTH-1:0]        io_i_coeff_index,
  input  logic                         io_i_dp1_wren,
  input  logic [ADDR_WIDTH-1:0]        io_i_dp1_wraddr,
  input  logic [LANES*DATA_WIDTH-1:0]  io_i_dp1_wrdata,
  input  logic [ADDR_WIDTH-1:0]        io_i_dp1_rdaddr,
  output logic [LANES*DATA_WIDTH-1:0]  io_o_dp1_rddata,
  input  logic [ADDR_WIDTH-1:0]        io_i_mux_rdaddr,
  output logic [LANES*DATA_WIDTH-1:0]  io_o_mux_rddata,
  output logic                         io_o_intt_we,
  output logic [ADDR_WIDTH-1:0]        io_o_intt_addr,
  output logic [LANES*COEFF_WIDTH-1:0] io_o_intt_concat,
  output logic                         io_o_fill_bank,
  output logic                         io_o_switch_pend,
  output logic [1:0]                   io_o_dbg_state
);
  import preprocess_pkg::*;

  localparam int WORD_W = LANES * COEFF_WIDTH;

  // Stream FSM
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] stream_addr;
  logic                  last_rd;

  // Beat output registers (aligned with the 1-cycle RAM latency)
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] intt_addr_q, intt_addr_d;

  // Bank control
  logic fill_bank_q, fill_bank_d;
  logic pend_q, pend_d;
  logic released_q, released_d;
  logic rd_sel_q;
  logic swap_req, swap_go;

  // Bank ports
  logic                  wren0, wren1;
  logic [ADDR_WIDTH-1:0] drain_rdaddr, rdaddr0, rdaddr1;
  logic [WORD_W-1:0]     wr_word, rd0, rd1, fill_raw, drain_raw;

  // Address wraps naturally modulo DEPTH.
  assign stream_addr = base_q + cnt_q;
  assign last_rd     = (cnt_q == '1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    case (state_q)
      ST_IDLE: begin
        if (io_i_intt_start) begin
          state_d = ST_STREAM;
          cnt_d   = '0;
          base_d  = io_i_coeff_index;
        end
      end
      ST_STREAM: begin
        cnt_d = cnt_q + 1'b1;
        if (last_rd) state_d = ST_FLUSH;
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
`ifdef PREPROCESS_BITREV_EN
    intt_addr_d = ADDR_WIDTH'(bitrev(ADDR_MAX_W'(stream_addr), ADDR_WIDTH));
`else
    intt_addr_d = stream_addr;
`endif
  end

  // A pending request is held until the FSM is idle and the mux side has
  // released the drain bank; repeated requests collapse into one swap.
  always_comb begin
    swap_req    = pend_q | io_i_pre_switch;
    swap_go     = swap_req && (state_q == ST_IDLE) && released_q;
    pend_d      = swap_req && !swap_go;
    fill_bank_d = fill_bank_q ^ swap_go;
    released_d  = released_q;
    if (io_i_mux_done) released_d = 1'b1;
    if (swap_go)       released_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      we_q        <= 1'b0;
      intt_addr_q <= '0;
      fill_bank_q <= 1'b0;
      pend_q      <= 1'b0;
      released_q  <= 1'b1;
      rd_sel_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      we_q        <= (state_q == ST_STREAM);
      intt_addr_q <= (state_q == ST_STREAM) ? intt_addr_d : '0;
      fill_bank_q <= fill_bank_d;
      pend_q      <= pend_d;
      released_q  <= released_d;
      // Read data follows the bank mapping in force when the read was issued.
      rd_sel_q    <= fill_bank_q;
    end
  end

  // Writes always target the current fill bank (old bank in a swap cycle).
  // The drain bank read port is shared: the stream owns it while streaming,
  // otherwise the mux port does.
  always_comb begin
    wren0        = io_i_dp1_wren & ~fill_bank_q;
    wren1        = io_i_dp1_wren &  fill_bank_q;
    drain_rdaddr = (state_q == ST_STREAM) ? stream_addr : io_i_mux_rdaddr;
    rdaddr0      = fill_bank_q ? drain_rdaddr : io_i_dp1_rdaddr;
    rdaddr1      = fill_bank_q ? io_i_dp1_rdaddr : drain_rdaddr;
    fill_raw     = rd_sel_q ? rd1 : rd0;
    drain_raw    = rd_sel_q ? rd0 : rd1;
  end

  // Lane packing: store the low COEFF_WIDTH bits, return zero-padded lanes.
  always_comb begin
    wr_word         = '0;
    io_o_dp1_rddata = '0;
    io_o_mux_rddata = '0;
    for (int l = 0; l < LANES; l++) begin
      wr_word[l*COEFF_WIDTH +: COEFF_WIDTH] = COEFF_WIDTH'(lane_zext(
          LANE_MAX_W'(io_i_dp1_wrdata[l*DATA_WIDTH +: DATA_WIDTH]), COEFF_WIDTH));
      io_o_dp1_rddata[l*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(lane_zext(
          LANE_MAX_W'(fill_raw[l*COEFF_WIDTH +: COEFF_WIDTH]), COEFF_WIDTH));
      io_o_mux_rddata[l*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(lane_zext(
          LANE_MAX_W'(drain_raw[l*COEFF_WIDTH +: COEFF_WIDTH]), COEFF_WIDTH));
    end
  end

  preprocess_bank_ram #(.WORD_W(WORD_W), .ADDR_WIDTH(ADDR_WIDTH)) u_bank0 (
    .clock_i  (clock),
    .reset_ni (reset),
    .wren_i   (wren0),
    .wraddr_i (io_i_dp1_wraddr),
    .wrdata_i (wr_word),
    .rdaddr_i (rdaddr0),
    .rddata_o (rd0)
  );

  preprocess_bank_ram #(.WORD_W(WORD_W), .ADDR_WIDTH(ADDR_WIDTH)) u_bank1 (
    .clock_i  (clock),
    .reset_ni (reset),
    .wren_i   (wren1),
    .wraddr_i (io_i_dp1_wraddr),
    .wrdata_i (wr_word),
    .rdaddr_i (rdaddr1),
    .rddata_o (rd1)
  );

  assign io_o_intt_done   = (state_q == ST_DONE);
  assign io_o_busy        = (state_q != ST_IDLE);
  assign io_o_intt_we     = we_q;
  assign io_o_intt_addr   = intt_addr_q;
  assign io_o_intt_concat = drain_raw;
  assign io_o_fill_bank   = fill_bank_q;
  assign io_o_switch_pend = pend_q;
  assign io_o_dbg_state   = state_q;

endmodule

// File: tb/tb_preprocess_pingpong_buf.sv
module tb_preprocess_pingpong_buf;

  localparam int DW = 39;
  localparam int CW = 35;
  localparam int AW = 4;
  localparam int L  = 2;

  typedef struct packed {
    logic [31:0]     cyc;
    logic [AW-1:0]   addr;
    logic [L*CW-1:0] data;
  } beat_t;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic            io_i_intt_start = 0, io_o_intt_done, io_o_busy;
  logic            io_i_pre_switch = 0, io_i_mux_done = 0;
  logic [AW-1:0]   io_i_coeff_index = 0;
  logic            io_i_dp1_wren = 0;
  logic [AW-1:0]   io_i_dp1_wraddr = 0, io_i_dp1_rdaddr = 0, io_i_mux_rdaddr = 0;
  logic [L*DW-1:0] io_i_dp1_wrdata = 0, io_o_dp1_rddata, io_o_mux_rddata;
  logic            io_o_intt_we, io_o_fill_bank, io_o_switch_pend;
  logic [AW-1:0]   io_o_intt_addr;
  logic [L*CW-1:0] io_o_intt_concat;
  logic [1:0]      io_o_dbg_state;

  preprocess_pingpong_buf #(.DATA_WIDTH(DW), .COEFF_WIDTH(CW), .ADDR_WIDTH(AW), .LANES(L)) dut (
    .clock            (clock),
    .reset            (reset),
    .io_i_intt_start  (io_i_intt_start),
    .io_o_intt_done   (io_o_intt_done),
    .io_o_busy        (io_o_busy),
    .io_i_pre_switch  (io_i_pre_switch),
    .io_i_mux_done    (io_i_mux_done),
    .io_i_coeff_index (io_i_coeff_index),
    .io_i_dp1_wren    (io_i_dp1_wren),
    .io_i_dp1_wraddr  (io_i_dp1_wraddr),
    .io_i_dp1_wrdata  (io_i_dp1_wrdata),
    .io_i_dp1_rdaddr  (io_i_dp1_rdaddr),
    .io_o_dp1_rddata  (io_o_dp1_rddata),
    .io_i_mux_rdaddr  (io_i_mux_rdaddr),
    .io_o_mux_rddata  (io_o_mux_rddata),
    .io_o_intt_we     (io_o_intt_we),
    .io_o_intt_addr   (io_o_intt_addr),
    .io_o_intt_concat (io_o_intt_concat),
    .io_o_fill_bank   (io_o_fill_bank),
    .io_o_switch_pend (io_o_switch_pend),
    .io_o_dbg_state   (io_o_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t exp_q[$];
  int    done_q[$];
  logic [L*CW-1:0] bank_m [2][16];
  int    fb_m = 0;
  beat_t mon_b;
  int    mon_d;

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [L*DW-1:0] pad(input logic [L*CW-1:0] w);
    return {4'b0, w[69:35], 4'b0, w[34:0]};
  endfunction

  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] a);
`ifdef PREPROCESS_BITREV_EN
    return {a[0], a[1], a[2], a[3]};
`else
    return a;
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr_word(input int a, input int l0, input int l1);
    io_i_dp1_wren   = 1'b1;
    io_i_dp1_wraddr = AW'(a);
    io_i_dp1_wrdata = {4'hA, 35'(l1), 4'h5, 35'(l0)};
    bank_m[fb_m][a] = {35'(l1), 35'(l0)};
    tick();
    io_i_dp1_wren = 1'b0;
  endtask

  task automatic pulse_switch();
    io_i_pre_switch = 1'b1;
    tick();
    io_i_pre_switch = 1'b0;
  endtask

  task automatic pulse_mux_done();
    io_i_mux_done = 1'b1;
    tick();
    io_i_mux_done = 1'b0;
  endtask

  // Issues a start and queues the expected beats (from the drain-bank model)
  // and the expected done cycle. Returns the cycle the start was presented.
  task automatic start_stream(input int idx, input int nbeats, input bit want_done,
                              output int s);
    beat_t b;
    int    a;
    s = cyc;
    io_i_intt_start  = 1'b1;
    io_i_coeff_index = AW'(idx);
    for (int k = 0; k < nbeats; k++) begin
      a      = (idx + k) % 16;
      b.cyc  = 32'(s + 2 + k);
      b.addr = exp_addr(AW'(a));
      b.data = bank_m[1-fb_m][a];
      exp_q.push_back(b);
    end
    if (want_done) done_q.push_back(s + 18);
    tick();
    io_i_intt_start = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (reset) begin
      if (io_o_intt_we) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL beat_unexpected: got beat addr %0d, expected no beat (cycle %0d)",
                   io_o_intt_addr, cyc);
        end else begin
          mon_b = exp_q.pop_front();
          check("beat_cycle", 128'(cyc), 128'(mon_b.cyc));
          check("beat_addr", 128'(io_o_intt_addr), 128'(mon_b.addr));
          check("beat_data", 128'(io_o_intt_concat), 128'(mon_b.data));
        end
      end
      if (io_o_intt_done) begin
        if (done_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL done_unexpected: got done pulse, expected none (cycle %0d)", cyc);
        end else begin
          mon_d = done_q.pop_front();
          check("done_cycle", 128'(cyc), 128'(mon_d));
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int s;
    logic [L*CW-1:0] old_w;

    repeat (3) @(posedge clock);
    #1;
    check("rst_we", 128'(io_o_intt_we), 0);
    check("rst_done", 128'(io_o_intt_done), 0);
    check("rst_busy", 128'(io_o_busy), 0);
    check("rst_fill_bank", 128'(io_o_fill_bank), 0);
    check("rst_pend", 128'(io_o_switch_pend), 0);
    check("rst_dp1_rd", 128'(io_o_dp1_rddata), 0);
    check("rst_mux_rd", 128'(io_o_mux_rddata), 0);
    check("rst_addr", 128'(io_o_intt_addr), 0);
    check("rst_concat", 128'(io_o_intt_concat), 0);
    check("rst_state", 128'(io_o_dbg_state), 0);
    reset = 1'b1;
    tick();

    // Fill bank0: addr a holds {a+100, a}; upper lane bits driven non-zero.
    for (int a = 0; a < 16; a++) wr_word(a, a, a + 100);

    io_i_dp1_rdaddr = 4'd3;
    tick();
    check("dp1_readback", 128'(io_o_dp1_rddata), 128'({4'b0, 35'd103, 4'b0, 35'd3}));

    // Same-address write and read in one cycle: old word first, new word next.
    old_w = bank_m[0][3];
    io_i_dp1_wren   = 1'b1;
    io_i_dp1_wraddr = 4'd3;
    io_i_dp1_wrdata = {4'hF, 35'd303, 4'hF, 35'd203};
    tick();
    io_i_dp1_wren = 1'b0;
    check("rd_first_old", 128'(io_o_dp1_rddata), 128'(pad(old_w)));
    bank_m[0][3] = {35'd303, 35'd203};
    tick();
    check("rd_first_new", 128'(io_o_dp1_rddata), 128'({4'b0, 35'd303, 4'b0, 35'd203}));

    // First swap: mux released, then switch.
    pulse_mux_done();
    pulse_switch();
    fb_m = 1;
    check("swap1_fill_bank", 128'(io_o_fill_bank), 1);
    check("swap1_pend", 128'(io_o_switch_pend), 0);

    io_i_mux_rdaddr = 4'd5;
    tick();
    check("mux_rd_5", 128'(io_o_mux_rddata), 128'({4'b0, 35'd105, 4'b0, 35'd5}));

    // Stream 1 from index 14: addrs 14,15,0..13; beat at addr 0 is {100,0}.
    start_stream(14, 16, 1'b1, s);
    wr_word(0, 7, 7);                    // fill bank1 only
    io_i_intt_start  = 1'b1;             // ignored while busy
    io_i_coeff_index = 4'd3;
    tick();
    io_i_intt_start = 1'b0;
    pulse_switch();                      // mux not released since swap1
    check("mid_pend", 128'(io_o_switch_pend), 1);
    check("mid_busy", 128'(io_o_busy), 1);
    check("mid_fill_bank", 128'(io_o_fill_bank), 1);
    while (cyc < s + 18) tick();
    check("pend_at_done", 128'(io_o_switch_pend), 1);
    tick();
    check("pend_done_plus1", 128'(io_o_switch_pend), 1);
    check("busy_after_done", 128'(io_o_busy), 0);
    tick();
    tick();
    check("pend_held_unreleased", 128'(io_o_switch_pend), 1);
    check("no_swap_unreleased", 128'(io_o_fill_bank), 1);
    pulse_switch();                      // absorbed into the pending request
    check("absorbed_fill_bank", 128'(io_o_fill_bank), 1);
    pulse_mux_done();
    tick();
    fb_m = 0;
    check("swap2_fill_bank", 128'(io_o_fill_bank), 0);
    check("swap2_pend", 128'(io_o_switch_pend), 0);
    tick();
    tick();
    check("no_double_swap", 128'(io_o_fill_bank), 0);

    // Drain bank is now bank1: the write made during streaming landed there.
    io_i_mux_rdaddr = 4'd0;
    tick();
    check("mux_rd_bank1", 128'(io_o_mux_rddata), 128'({4'b0, 35'd7, 4'b0, 35'd7}));

    pulse_mux_done();
    pulse_switch();
    fb_m = 1;
    check("swap3_fill_bank", 128'(io_o_fill_bank), 1);

    // Stream 2 from index 0; a start in the done cycle is ignored.
    start_stream(0, 16, 1'b1, s);
    while (cyc < s + 18) tick();
    io_i_intt_start  = 1'b1;
    io_i_coeff_index = 4'd5;
    tick();
    io_i_intt_start = 1'b0;
    tick();
    check("start_at_done_busy", 128'(io_o_busy), 0);
    check("start_at_done_state", 128'(io_o_dbg_state), 0);

    // Stream 3: reset during beat 7 aborts with no done.
    start_stream(9, 7, 1'b0, s);
    while (cyc < s + 8) tick();
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("abort_we", 128'(io_o_intt_we), 0);
    check("abort_done", 128'(io_o_intt_done), 0);
    check("abort_busy", 128'(io_o_busy), 0);
    check("abort_fill_bank", 128'(io_o_fill_bank), 0);
    check("abort_state", 128'(io_o_dbg_state), 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    fb_m  = 0;
    tick();

    // After reset the mux side counts as released: swap applies at once.
    pulse_switch();
    fb_m = 1;
    check("post_reset_swap", 128'(io_o_fill_bank), 1);

    repeat (3) tick();
    check("beats_consumed", 128'(exp_q.size()), 0);
    check("dones_consumed", 128'(done_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
